// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer that shares one single-port
// word memory between instruction fetch (port 0, read-only) and load/store
// (port 1, read/write). One transaction is in flight at a time; the response
// is held until the owning requester takes it.
module mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   p0_req_valid,
    output logic                   p0_req_ready,
    input  logic [XLEN-1:0]        p0_req_addr,
    output logic                   p0_resp_valid,
    input  logic                   p0_resp_ready,
    output logic [XLEN-1:0]        p0_resp_data,
    input  logic                   p1_req_valid,
    output logic                   p1_req_ready,
    input  logic [XLEN-1:0]        p1_req_addr,
    input  logic                   p1_req_wen,
    input  logic [BLOCK_BYTES-1:0] p1_req_wmask,
    input  logic [XLEN-1:0]        p1_req_wdata,
    output logic                   p1_resp_valid,
    input  logic                   p1_resp_ready,
    output logic [XLEN-1:0]        p1_resp_data,
    output logic                   mem_wen,
    output logic [XLEN-1:0]        mem_waddr,
    output logic [BLOCK_BYTES-1:0] mem_wmask,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [XLEN-1:0]        mem_raddr,
    input  logic [XLEN-1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   last_grant;
    logic                   owner;
    logic                   lat_wen;
    logic [XLEN-1:0]        lat_addr;
    logic [XLEN-1:0]        lat_wdata;
    logic [BLOCK_BYTES-1:0] lat_wmask;
    logic [XLEN-1:0]        resp_data;
    logic                   owner_resp_ready;

    // The latched request drives both memory address ports, so the read
    // address simply stays on the last word while idle or waiting.
    assign mem_raddr        = lat_addr;
    assign mem_waddr        = lat_addr;
    assign mem_wmask        = lat_wmask;
    assign mem_wdata        = lat_wdata;
    assign p0_resp_data     = resp_data;
    assign p1_resp_data     = resp_data;
    assign owner_resp_ready = owner ? p1_resp_ready : p0_resp_ready;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, handshakes, write strobe and next-state selection
    always_comb begin
        state_next    = state;
        p0_req_ready  = 1'b0;
        p1_req_ready  = 1'b0;
        p0_resp_valid = 1'b0;
        p1_resp_valid = 1'b0;
        mem_wen       = 1'b0;
        case (state)
            IDLE: begin
                p0_req_ready = p0_req_valid && (!p1_req_valid || last_grant);
                p1_req_ready = p1_req_valid && (!p0_req_valid || !last_grant);
                if (p0_req_ready || p1_req_ready) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_wen    = lat_wen;
                state_next = lat_wen ? RESP : RDATA;
            end
            RDATA: begin
                state_next = RESP;
            end
            RESP: begin
                p0_resp_valid = !owner;
                p1_resp_valid = owner;
                if (owner_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who was served last
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wmask  <= '0;
            lat_wdata  <= '0;
        end else if (p0_req_ready) begin
            last_grant <= 1'b0;
            owner      <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= p0_req_addr;
            lat_wmask  <= '0;
            lat_wdata  <= '0;
        end else if (p1_req_ready) begin
            last_grant <= 1'b1;
            owner      <= 1'b1;
            lat_wen    <= p1_req_wen;
            lat_addr   <= p1_req_addr;
            lat_wmask  <= p1_req_wmask;
            lat_wdata  <= p1_req_wdata;
        end
    end

    // Response buffer: zero for a write ack, memory data for a read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_data <= '0;
        end else if (state == ISSUE && lat_wen) begin
            resp_data <= '0;
        end else if (state == RDATA) begin
            resp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized check of mem_arbiter against a
// transaction-level reference model, with a behavioural word memory attached.
module tb_mem_arbiter;

    localparam int XLEN        = 32;
    localparam int BLOCK_BYTES = 4;
    localparam int WORDS       = 64;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_ready;
    logic [XLEN-1:0]        p0_req_addr, p0_resp_data;
    logic                   p1_req_valid, p1_req_ready, p1_req_wen, p1_resp_valid, p1_resp_ready;
    logic [XLEN-1:0]        p1_req_addr, p1_req_wdata, p1_resp_data;
    logic [BLOCK_BYTES-1:0] p1_req_wmask;
    logic                   mem_wen;
    logic [XLEN-1:0]        mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    logic [BLOCK_BYTES-1:0] mem_wmask;

    mem_arbiter #(.XLEN(XLEN), .BLOCK_BYTES(BLOCK_BYTES)) dut (
        .clock(clock), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_data(p0_resp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_wen(p1_req_wen), .p1_req_wmask(p1_req_wmask), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_data(p1_resp_data),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] initWord(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // Single-port word memory: registered read, write wins, no read on a write cycle
    logic [XLEN-1:0] tb_mem [WORDS];
    logic            mem_loaded = 1'b0;
    logic [XLEN-1:0] merge_word;
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < WORDS; i++) tb_mem[i] <= initWord(i);
            mem_loaded <= 1'b1;
        end else if (mem_wen) begin
            merge_word = tb_mem[mem_waddr[7:2]];
            for (int b = 0; b < BLOCK_BYTES; b++)
                if (mem_wmask[b]) merge_word[8*b +: 8] = mem_wdata[8*b +: 8];
            tb_mem[mem_waddr[7:2]] <= merge_word;
        end else begin
            mem_rdata <= tb_mem[mem_raddr[7:2]];
        end
    end

    // Reference model state: one outstanding transaction described by its
    // accept cycle, owner, kind and the data it must return.
    logic [XLEN-1:0]        ref_mem [WORDS];
    bit                     busy;
    int                     last_winner, m_owner, acc_cycle, resp_start, cyc;
    bit                     m_wen;
    logic [XLEN-1:0]        m_addr, m_wdata, m_data;
    logic [BLOCK_BYTES-1:0] m_wmask;
    int                     compared, mismatched, grants0, grants1;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_wen"}, mem_wen, 0);
        checkOutput({tag, "_mem_raddr"}, mem_raddr, 0);
        checkOutput({tag, "_mem_waddr"}, mem_waddr, 0);
        checkOutput({tag, "_mem_wmask"}, mem_wmask, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_p0_resp_valid"}, p0_resp_valid, 0);
        checkOutput({tag, "_p1_resp_valid"}, p1_resp_valid, 0);
        checkOutput({tag, "_p0_resp_data"}, p0_resp_data, 0);
        checkOutput({tag, "_p1_resp_data"}, p1_resp_data, 0);
        checkOutput({tag, "_p0_req_ready"}, p0_req_ready, 0);
        checkOutput({tag, "_p1_req_ready"}, p1_req_ready, 0);
    endtask

    // Compare the DUT against the model for this cycle, then advance the model
    task automatic modelCycle();
        int              winner;
        int              idx;
        bit              in_resp;
        bit              wen_cycle;
        logic [XLEN-1:0] w;
        winner = -1;
        if (!busy) begin
            if (p0_req_valid && p1_req_valid) winner = (last_winner == 0) ? 1 : 0;
            else if (p0_req_valid) winner = 0;
            else if (p1_req_valid) winner = 1;
        end
        in_resp   = busy && (cyc >= resp_start);
        wen_cycle = busy && m_wen && (cyc == acc_cycle + 1);
        if (p0_req_ready) grants0++;
        if (p1_req_ready) grants1++;
        checkOutput("p0_req_ready", p0_req_ready, winner == 0);
        checkOutput("p1_req_ready", p1_req_ready, winner == 1);
        checkOutput("p0_resp_valid", p0_resp_valid, in_resp && m_owner == 0);
        checkOutput("p1_resp_valid", p1_resp_valid, in_resp && m_owner == 1);
        if (in_resp)
            checkOutput("resp_data", (m_owner == 1) ? p1_resp_data : p0_resp_data, m_data);
        checkOutput("mem_wen", mem_wen, wen_cycle);
        if (busy && cyc > acc_cycle) begin
            checkOutput("mem_raddr", mem_raddr, m_addr);
            checkOutput("mem_waddr", mem_waddr, m_addr);
        end
        if (wen_cycle) begin
            checkOutput("mem_wmask", mem_wmask, m_wmask);
            checkOutput("mem_wdata", mem_wdata, m_wdata);
        end
        if (winner >= 0) begin
            busy        = 1;
            m_owner     = winner;
            last_winner = winner;
            acc_cycle   = cyc;
            m_addr      = (winner == 0) ? p0_req_addr : p1_req_addr;
            m_wen       = (winner == 1) && p1_req_wen;
            m_wmask     = p1_req_wmask;
            m_wdata     = p1_req_wdata;
            resp_start  = cyc + (m_wen ? 2 : 3);
            idx         = int'(m_addr[7:2]);
            if (m_wen) begin
                m_data = '0;
                w = ref_mem[idx];
                for (int b = 0; b < BLOCK_BYTES; b++)
                    if (m_wmask[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                ref_mem[idx] = w;
            end else begin
                m_data = ref_mem[idx];
            end
        end else if (in_resp && ((m_owner == 1) ? p1_resp_ready : p0_resp_ready)) begin
            busy = 0;
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, step past the rising edge
    task automatic applyStimulus(input logic v0, input logic [XLEN-1:0] a0, input logic rr0,
                                 input logic v1, input logic [XLEN-1:0] a1, input logic wen,
                                 input logic [BLOCK_BYTES-1:0] wm, input logic [XLEN-1:0] wd,
                                 input logic rr1);
        p0_req_valid  = v0;  p0_req_addr  = a0;  p0_resp_ready = rr0;
        p1_req_valid  = v1;  p1_req_addr  = a1;  p1_req_wen    = wen;
        p1_req_wmask  = wm;  p1_req_wdata = wd;  p1_resp_ready = rr1;
        @(negedge clock);
        modelCycle();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0; busy = 0; last_winner = 1;
        grants0 = 0; grants1 = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = initWord(i);
        reset = 1'b1;
        p0_req_valid = 0; p0_req_addr = 0; p0_resp_ready = 0;
        p1_req_valid = 0; p1_req_addr = 0; p1_req_wen = 0;
        p1_req_wmask = 0; p1_req_wdata = 0; p1_resp_ready = 0;
        repeat (2) @(posedge clock);
        #1 checkResetValues("reset");
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        // Fetch read of word 4
        applyStimulus(1, 32'h10, 1, 0, 0, 0, 0, 0, 1);
        idleCycles(5);

        // Full write, read back, masked write, read back
        applyStimulus(0, 0, 1, 1, 32'h20, 1, 4'hF, 32'h12345678, 1);
        idleCycles(4);
        checkOutput("full_write_mem", tb_mem[8], 32'h12345678);
        applyStimulus(0, 0, 1, 1, 32'h20, 0, 0, 0, 1);
        idleCycles(5);
        applyStimulus(0, 0, 1, 1, 32'h20, 1, 4'h3, 32'hAAAABBBB, 1);
        idleCycles(4);
        checkOutput("masked_write_mem", tb_mem[8], 32'h1234BBBB);
        applyStimulus(0, 0, 1, 1, 32'h20, 0, 0, 0, 1);
        idleCycles(5);

        // Zero-mask write still acknowledges and leaves memory alone
        applyStimulus(0, 0, 1, 1, 32'h20, 1, 4'h0, 32'hFFFFFFFF, 1);
        idleCycles(4);
        checkOutput("zero_mask_mem", tb_mem[8], 32'h1234BBBB);

        // Both ports saturated: eight reads alternate between the ports
        grants0 = 0; grants1 = 0;
        for (int i = 0; i < 32; i++)
            applyStimulus(1, 32'($urandom_range(0, 255)), 1, 1, 32'($urandom_range(0, 255)), 0, 0, 0, 1);
        checkOutput("fair_p0_grants", grants0, 4);
        checkOutput("fair_p1_grants", grants1, 4);
        idleCycles(5);

        // Fetch consumer stalls while load/store keeps asking
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 32'h24, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 32'h24, 0, 0, 0, 1);
        idleCycles(6);

        // Reset while the read data is being captured
        applyStimulus(1, 32'h10, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        #1 checkResetValues("mid_reset");
        busy = 0; last_winner = 1;
        @(negedge clock) reset = 1'b0;
        @(posedge clock); cyc++; #1;
        applyStimulus(1, 32'h10, 1, 1, 32'h20, 0, 0, 0, 1);
        idleCycles(4);
        applyStimulus(0, 0, 1, 1, 32'h20, 0, 0, 0, 1);
        idleCycles(5);

        // Random traffic, including dropped requests and stalled consumers
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 99) < 60, 32'($urandom_range(0, 255)),
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 60, 32'($urandom_range(0, 255)),
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                          32'($urandom), $urandom_range(0, 99) < 60);
        idleCycles(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
